// File: rtl/c_realign_buf.sv
// c_realign_buf: RV32C instruction realignment buffer between fetch and decode.
// Aligned fetch words are split into 16-bit parcels and queued. Each cycle the
// head of the queue is presented to decode as a single complete instruction:
// either a 16-bit compressed one or a 32-bit one, which may straddle two fetch
// words.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   flush_i             redirect to redirect_pc_i; the queue is cleared
//   redirect_pc_i       redirect target (bit 0 ignored)
//   fetch_valid_i/      fetch word handshake; fetch_data_i parcel 0 in [15:0]
//   fetch_ready_o/
//   fetch_data_i
//   inst_valid_o/       instruction handshake toward decode
//   inst_ready_i
//   inst_o              instruction (compressed zero-extended)
//   inst_pc_o           PC of the presented instruction
//   inst_is_c_o         presented instruction is compressed
//   pc_misaligned_o     presented 32-bit instruction spans two fetch words
//   stall_pc_o          inverse of fetch_ready_o
module c_realign_buf #(
  parameter int              XLEN     = 32,
  parameter int              FETCH_W  = 32,
  parameter int              DEPTH_HW = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  input  logic               fetch_valid_i,
  output logic               fetch_ready_o,
  input  logic [FETCH_W-1:0] fetch_data_i,
  output logic               inst_valid_o,
  input  logic               inst_ready_i,
  output logic [31:0]        inst_o,
  output logic [XLEN-1:0]    inst_pc_o,
  output logic               inst_is_c_o,
  output logic               pc_misaligned_o,
  output logic               stall_pc_o
);

  localparam int NP = FETCH_W / 16;          // parcels per fetch word
  localparam int PW = $clog2(DEPTH_HW);      // pointer width
  localparam int CW = PW + 1;                // count width, holds 0..DEPTH_HW
  localparam int OB = $clog2(FETCH_W / 8);   // byte-offset bits within a fetch word
  localparam int DW = OB - 1;                // parcel-offset bits within a fetch word

  logic [15:0]     mem [DEPTH_HW];
  logic [PW-1:0]   head;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] head_pc;
  logic [DW-1:0]   drop;

  logic [15:0]     parcel0;
  logic [15:0]     parcel1;
  logic            avail;
  logic            push;
  logic            pop;
  logic [CW-1:0]   n_push;
  logic [CW-1:0]   n_pop;

  always_comb begin
    parcel0         = mem[head];
    parcel1         = mem[head + PW'(1)];
    inst_is_c_o     = (parcel0[1:0] != 2'b11);
    avail           = inst_is_c_o ? (count >= CW'(1)) : (count >= CW'(2));
    inst_valid_o    = avail && !flush_i;
    // Registered count only; a pop in this cycle does not open room early.
    fetch_ready_o   = (CW'(DEPTH_HW) - count) >= CW'(NP);
    stall_pc_o      = !fetch_ready_o;
    push            = fetch_valid_i && fetch_ready_o && !flush_i;
    pop             = inst_valid_o && inst_ready_i;
    n_push          = push ? (CW'(NP) - CW'(drop)) : '0;
    n_pop           = pop ? (inst_is_c_o ? CW'(1) : CW'(2)) : '0;
    inst_o          = inst_is_c_o ? {16'h0000, parcel0} : {parcel1, parcel0};
    inst_pc_o       = head_pc;
    // Head sits on the last parcel of a fetch word, so the upper half comes from the next word.
    pc_misaligned_o = inst_valid_o && !inst_is_c_o && (&head_pc[OB-1:1]);
  end

  // Parcel storage carries no reset; only count decides what is live.
  // Dropped leading parcels (mid-word redirect entry) are skipped and the rest packed at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < NP; i++) begin
        if (i >= int'(drop)) begin
          mem[head + PW'(count) + PW'(i) - PW'(drop)] <= fetch_data_i[16*i +: 16];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head    <= '0;
      count   <= '0;
      head_pc <= RESET_PC;
      drop    <= '0;
    end else if (flush_i) begin
      head    <= '0;
      count   <= '0;
      head_pc <= redirect_pc_i & ~XLEN'(1);
      drop    <= redirect_pc_i[OB-1:1];
    end else begin
      count <= count + n_push - n_pop;
      head  <= head + PW'(n_pop);
      if (pop) begin
        head_pc <= head_pc + (inst_is_c_o ? XLEN'(2) : XLEN'(4));
      end
      if (push) begin
        drop <= '0;
      end
    end
  end

endmodule

// File: tb/tb_c_realign_buf.sv
// tb_c_realign_buf: directed bench for c_realign_buf. Two instances share the
// clock: "a" with 32-bit fetch and RESET_PC 0, "b" with 64-bit fetch and
// RESET_PC 32'h80. Expected instructions are queued when stimulus is driven
// and popped whenever the active instance completes an instruction handshake.
module tb_c_realign_buf;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        c;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, fl_a, fv_a, rdy_a;
  logic [31:0] rpc_a, fd_a;
  logic        fr_a, v_a, c_a, mis_a, st_a;
  logic [31:0] inst_a, pc_a;

  logic        rst_b, fl_b, fv_b, rdy_b;
  logic [31:0] rpc_b;
  logic [63:0] fd_b;
  logic        fr_b, v_b, c_b, mis_b, st_b;
  logic [31:0] inst_b, pc_b;

  c_realign_buf #(.XLEN(32), .FETCH_W(32), .DEPTH_HW(8), .RESET_PC(32'h0)) dut_a (
    .clk(clk), .reset_n(rst_a), .flush_i(fl_a), .redirect_pc_i(rpc_a),
    .fetch_valid_i(fv_a), .fetch_ready_o(fr_a), .fetch_data_i(fd_a),
    .inst_valid_o(v_a), .inst_ready_i(rdy_a), .inst_o(inst_a), .inst_pc_o(pc_a),
    .inst_is_c_o(c_a), .pc_misaligned_o(mis_a), .stall_pc_o(st_a)
  );

  c_realign_buf #(.XLEN(32), .FETCH_W(64), .DEPTH_HW(8), .RESET_PC(32'h80)) dut_b (
    .clk(clk), .reset_n(rst_b), .flush_i(fl_b), .redirect_pc_i(rpc_b),
    .fetch_valid_i(fv_b), .fetch_ready_o(fr_b), .fetch_data_i(fd_b),
    .inst_valid_o(v_b), .inst_ready_i(rdy_b), .inst_o(inst_b), .inst_pc_o(pc_b),
    .inst_is_c_o(c_b), .pc_misaligned_o(mis_b), .stall_pc_o(st_b)
  );

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void exp_push(input logic [31:0] inst, input logic [31:0] pc,
                                   input logic c, input logic mis);
    exp_t e;
    e.inst = inst; e.pc = pc; e.c = c; e.mis = mis;
    sb.push_back(e);
  endfunction

  task automatic mon(input logic v, input logic rdy, input logic [31:0] inst,
                     input logic [31:0] pc, input logic c, input logic mis);
    exp_t e;
    if (!v) begin
      chk("mis_idle", {63'h0, mis}, 64'h0);
    end else if (rdy) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $error("FAIL unexpected_inst observed=%h@%h expected=none", inst, pc);
      end else begin
        e = sb.pop_front();
        assert ({inst, pc, c, mis} === {e.inst, e.pc, e.c, e.mis}) else begin
          errors++;
          $error("FAIL inst observed=%h@%h c=%b mis=%b expected=%h@%h c=%b mis=%b",
                 inst, pc, c, mis, e.inst, e.pc, e.c, e.mis);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_a(input logic fv, input logic [31:0] fd, input logic rdy,
                         input logic fl, input logic [31:0] rpc);
    fv_a = fv; fd_a = fd; rdy_a = rdy; fl_a = fl; rpc_a = rpc;
    #1 mon(v_a, rdy_a, inst_a, pc_a, c_a, mis_a);
  endtask

  task automatic drive_b(input logic fv, input logic [63:0] fd, input logic rdy,
                         input logic fl, input logic [31:0] rpc);
    fv_b = fv; fd_b = fd; rdy_b = rdy; fl_b = fl; rpc_b = rpc;
    #1 mon(v_b, rdy_b, inst_b, pc_b, c_b, mis_b);
  endtask

  task automatic drain_a(input int n);
    for (int i = 0; i < n; i++) begin
      drive_a(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      tick();
    end
    chk("a_sb_empty", 64'(sb.size()), 64'h0);
    drive_a(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("a_idle_valid", {63'h0, v_a}, 64'h0);
  endtask

  task automatic drain_b(input int n);
    for (int i = 0; i < n; i++) begin
      drive_b(1'b0, 64'h0, 1'b1, 1'b0, 32'h0);
      tick();
    end
    chk("b_sb_empty", 64'(sb.size()), 64'h0);
    drive_b(1'b0, 64'h0, 1'b1, 1'b0, 32'h0);
    chk("b_idle_valid", {63'h0, v_b}, 64'h0);
  endtask

  initial begin
    logic [15:0] p0, p1;
    rst_a = 1'b0; fl_a = 1'b0; fv_a = 1'b0; rdy_a = 1'b0; rpc_a = '0; fd_a = '0;
    rst_b = 1'b0; fl_b = 1'b0; fv_b = 1'b0; rdy_b = 1'b0; rpc_b = '0; fd_b = '0;
    tick();
    tick();
    rst_a = 1'b1;
    rst_b = 1'b1;

    // reset state and basic C / straddling 32-bit / C sequence
    drive_a(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("rst_valid", {63'h0, v_a}, 64'h0);
    chk("rst_ready", {63'h0, fr_a}, 64'h1);
    chk("rst_stall", {63'h0, st_a}, 64'h0);
    tick();
    exp_push(32'h0000c104, 32'h0, 1'b1, 1'b0);
    exp_push(32'h0040006f, 32'h2, 1'b0, 1'b1);
    exp_push(32'h00004104, 32'h6, 1'b1, 1'b0);
    drive_a(1'b1, 32'h006fc104, 1'b1, 1'b0, 32'h0);
    tick();
    drive_a(1'b1, 32'h41040040, 1'b1, 1'b0, 32'h0);
    tick();
    drain_a(6);
    tick();

    // backpressure: fill to 8 parcels, head_pc now 8
    for (int k = 0; k < 4; k++) begin
      p0 = 16'h2000 | 16'((2*k) << 2);
      p1 = 16'h2000 | 16'((2*k+1) << 2);
      exp_push({16'h0, p0}, 32'(8 + 4*k), 1'b1, 1'b0);
      exp_push({16'h0, p1}, 32'(10 + 4*k), 1'b1, 1'b0);
      drive_a(1'b1, {p1, p0}, 1'b0, 1'b0, 32'h0);
      chk("bp_ready_before_full", {63'h0, fr_a}, 64'h1);
      tick();
    end
    drive_a(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("bp_full_ready", {63'h0, fr_a}, 64'h0);
    chk("bp_full_stall", {63'h0, st_a}, 64'h1);
    chk("bp_full_valid", {63'h0, v_a}, 64'h1);
    chk("bp_hold_inst", {32'h0, inst_a}, 64'h2000);
    tick();
    drive_a(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("bp_stable_inst", {32'h0, inst_a}, 64'h2000);
    chk("bp_stable_pc", {32'h0, pc_a}, 64'h8);
    tick();
    drive_a(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    drive_a(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("bp_count7_ready", {63'h0, fr_a}, 64'h0);
    tick();
    drive_a(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    drive_a(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("bp_count6_ready", {63'h0, fr_a}, 64'h1);
    tick();
    drain_a(8);
    tick();

    // flush to 0x102: first parcel of the next word is dropped
    drive_a(1'b0, 32'h0, 1'b1, 1'b1, 32'h102);
    tick();
    exp_push(32'h00004104, 32'h102, 1'b1, 1'b0);
    drive_a(1'b1, 32'h41040001, 1'b1, 1'b0, 32'h0);
    tick();
    drain_a(4);
    tick();

    // flush coinciding with fetch push and instruction handshake
    drive_a(1'b1, 32'h00080004, 1'b0, 1'b0, 32'h0);
    tick();
    drive_a(1'b1, 32'h000c0008, 1'b1, 1'b1, 32'h200);
    chk("flush_gate_valid", {63'h0, v_a}, 64'h0);
    tick();
    drive_a(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("post_flush_valid", {63'h0, v_a}, 64'h0);
    chk("post_flush_ready", {63'h0, fr_a}, 64'h1);
    tick();
    exp_push(32'h00000010, 32'h200, 1'b1, 1'b0);
    exp_push(32'h00000014, 32'h202, 1'b1, 1'b0);
    drive_a(1'b1, 32'h00140010, 1'b1, 1'b0, 32'h0);
    tick();
    drain_a(4);
    tick();

    // async reset with 5 parcels queued
    drive_a(1'b0, 32'h0, 1'b0, 1'b1, 32'h302);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive_a(1'b1, 32'h00340030, 1'b0, 1'b0, 32'h0);
      tick();
    end
    drive_a(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("pre_rst_valid", {63'h0, v_a}, 64'h1);
    #1 rst_a = 1'b0;
    #1 chk("async_rst_valid", {63'h0, v_a}, 64'h0);
    chk("async_rst_ready", {63'h0, fr_a}, 64'h1);
    chk("async_rst_stall", {63'h0, st_a}, 64'h0);
    tick();
    tick();
    rst_a = 1'b1;
    exp_push(32'h00000020, 32'h0, 1'b1, 1'b0);
    exp_push(32'h00000024, 32'h2, 1'b1, 1'b0);
    drive_a(1'b1, 32'h00240020, 1'b1, 1'b0, 32'h0);
    tick();
    drain_a(4);
    tick();

    // 64-bit fetch instance: reset PC, then mid-word redirect with 3 dropped parcels
    drive_b(1'b0, 64'h0, 1'b0, 1'b0, 32'h0);
    chk("b_rst_valid", {63'h0, v_b}, 64'h0);
    chk("b_rst_ready", {63'h0, fr_b}, 64'h1);
    tick();
    exp_push(32'h00000004, 32'h80, 1'b1, 1'b0);
    exp_push(32'h00000000, 32'h82, 1'b1, 1'b0);
    exp_push(32'h00000000, 32'h84, 1'b1, 1'b0);
    exp_push(32'h00000000, 32'h86, 1'b1, 1'b0);
    drive_b(1'b1, 64'h0000_0000_0000_0004, 1'b1, 1'b0, 32'h0);
    tick();
    drain_b(6);
    tick();
    drive_b(1'b0, 64'h0, 1'b1, 1'b1, 32'h6);
    tick();
    exp_push(32'h00000000, 32'h6,  1'b1, 1'b0);
    exp_push(32'h00000013, 32'h8,  1'b0, 1'b0);
    exp_push(32'h00004104, 32'hc,  1'b1, 1'b0);
    exp_push(32'h12340093, 32'he,  1'b0, 1'b1);
    exp_push(32'h00000004, 32'h12, 1'b1, 1'b0);
    exp_push(32'h00000008, 32'h14, 1'b1, 1'b0);
    exp_push(32'h0000000c, 32'h16, 1'b1, 1'b0);
    drive_b(1'b1, 64'h0000_0013_0001_0001, 1'b1, 1'b0, 32'h0);
    tick();
    drive_b(1'b1, 64'h0093_4104_0000_0013, 1'b1, 1'b0, 32'h0);
    tick();
    drive_b(1'b1, 64'h000c_0008_0004_1234, 1'b1, 1'b0, 32'h0);
    tick();
    drain_b(10);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/c_realign_buf.md
# c_realign_buf

Parametrised instruction realignment buffer between the fetch stage and decode for the RV32C extension. Accepts aligned fetch words of FETCH_W bits, queues them as 16-bit parcels and presents exactly one complete instruction per cycle (16-bit compressed or 32-bit, including 32-bit instructions straddling a fetch-word boundary) with its PC. It supports wider fetch, a multi-word parcel queue, valid/ready handshakes on both sides and branch-redirect flush with mid-word entry.

## Interface
- XLEN, 32, PC width.
- FETCH_W, 32, fetch word width; legal values 32 or 64.
- DEPTH_HW, 8, queue depth in 16-bit parcels; power of two, at least 2*FETCH_W/16.
- RESET_PC, 32'h0, head PC after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush_i  in  1  taken branch/jump; redirect to redirect_pc_i.
- redirect_pc_i  in  XLEN  redirect target; bit 0 ignored.
- fetch_valid_i  in  1  fetch word valid.
- fetch_ready_o  out  1  buffer can accept a full fetch word.
- fetch_data_i  in  FETCH_W  fetch word; parcel 0 in bits [15:0].
- inst_valid_o  out  1  complete instruction presented.
- inst_ready_i  in  1  decode consumes instruction.
- inst_o  out  32  instruction; compressed zero-extended to {16'h0, parcel}.
- inst_pc_o  out  XLEN  PC of presented instruction.
- inst_is_c_o  out  1  presented instruction is compressed.
- pc_misaligned_o  out  1  presented 32-bit instruction spans two fetch words.
- stall_pc_o  out  1  equals !fetch_ready_o; stalls PC generation.

## Operation
- State: parcel queue (DEPTH_HW x 16), head pointer, count (0..DEPTH_HW), head_pc, drop counter (0..FETCH_W/16-1).
- Fetch accept (fetch_valid_i && fetch_ready_o && !flush_i): push all FETCH_W/16 parcels in ascending order, minus the first drop parcels. drop then clears.
- fetch_ready_o = (DEPTH_HW - count) >= FETCH_W/16, from registered count only (no same-cycle pop lookahead).
- Decode of head parcel: bits [1:0] != 2'b11 -> compressed, valid if count >= 1. Otherwise 32-bit, valid if count >= 2, inst_o = {parcel1, parcel0}.
- inst_valid_o gated low while flush_i = 1.
- Pop on inst_valid_o && inst_ready_i: remove 1 (C) or 2 parcels. head_pc += 2 or 4, wrapping modulo 2^XLEN.
- Simultaneous push and pop in one cycle: count += pushed - popped.
- pc_misaligned_o = inst_valid_o && !inst_is_c_o && head_pc[log2(FETCH_W/8)-1:1] all ones.
- Flush: next edge clears queue (count = 0), head_pc = {redirect_pc_i[XLEN-1:1], 1'b0}, drop = redirect_pc_i[log2(FETCH_W/8)-1:1]. Fetch word and inst handshake in the flush cycle are discarded.
- Pointers wrap modulo DEPTH_HW. Count never exceeds DEPTH_HW by construction.
- Reset (async assert): count = 0, drop = 0, head_pc = RESET_PC. inst_valid_o = 0 and fetch_ready_o = 1 immediately.

## Timing
- Latency: a parcel pushed at edge N is visible at inst_o in cycle N+1 (registered queue, no bypass).
- Throughput: one instruction per cycle while parcels are available.
- inst_o, inst_pc_o, inst_is_c_o are stable while inst_valid_o = 1 and inst_ready_i = 0, absent flush/reset.
- Outputs other than inst_valid_o/pc_misaligned_o are don't-care when inst_valid_o = 0.
- Flush has priority over push and pop. Reset has priority over everything.
- Reset deassertion is synchronised externally; the first capture is on the first rising edge with reset_n high.

## Test plan
- FETCH_W=32, RESET_PC=0: push 32'h006fc104 then 32'h41040040, inst_ready_i=1 -> C 16'hc104 @pc 0; 32'h0040006f @pc 2 with pc_misaligned_o=1; C 16'h4104 @pc 6.
- Backpressure, DEPTH_HW=8, inst_ready_i=0: four pushes -> count 8, fetch_ready_o=0, stall_pc_o=1. One compressed pop -> still not ready (count 7). Second pop -> ready (count 6).
- Flush with redirect_pc_i=32'h102, then push 32'h41040001 -> parcel 0001 dropped; first output C 16'h4104 @pc 32'h102.
- Flush in the same cycle as fetch_valid_i and inst handshake -> inst_valid_o=0 that cycle; next cycle count 0, head_pc=redirect target, no instruction emitted from the discarded word.
- FETCH_W=64, redirect_pc_i=32'h6, push 64'h0000_0013_0001_0001 -> 3 parcels dropped; first parcel 16'h0000 is compressed @pc 6. Next 64-bit word's low parcel starts at pc 8.
- Async reset mid-stream with count 5 -> inst_valid_o falls without a clock edge, fetch_ready_o=1. After release, first push is output at pc RESET_PC.
